// File: rtl/ram64_loader.sv
// ram64_loader: sequential write-stream front end for the 64 x 16 RAM64 block.
// Streams a burst of words (LOAD) or zero-fills a region (CLEAR) at consecutive
// addresses from a programmable base, wrapping modulo 64.
// Optional build macro RAM64_LOADER_CHECKSUM_EN adds o_checksum, the 16-bit sum
// of every word written during LOAD.
module ram64_loader (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_clear_mode,
    input  logic [5:0]  i_base_addr,
    input  logic [6:0]  i_length,
    input  logic [15:0] i_s_data,
    input  logic        i_s_valid,
    output logic        o_s_ready,
    output logic [15:0] o_ram_in,
    output logic [5:0]  o_ram_addr,
    output logic        o_ram_load,
    output logic        o_busy,
    output logic        o_done,
`ifdef RAM64_LOADER_CHECKSUM_EN
    output logic [6:0]  o_word_count,
    output logic [15:0] o_checksum
`else
    output logic [6:0]  o_word_count
`endif
);

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned MAX_LEN = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_len;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_word_count;
    logic [DATA_W-1:0]   r_ram_in;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic                r_ram_load;

    logic [CNT_W-1:0]    w_len_clamped;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_last;

    // Lengths above 64 collapse to a full sweep of the RAM
    assign w_len_clamped = (i_length > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : i_length;
    // Target address wraps naturally in the 6-bit sum
    assign w_addr        = ADDR_W'(r_base + r_count[ADDR_W-1:0]);
    assign w_last        = (CNT_W'(r_count + CNT_W'(1)) == r_len);

    // Status outputs decoded straight from the state register
    assign o_s_ready    = (r_state == ST_LOAD);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = (r_state == ST_DONE);
    assign o_ram_in     = r_ram_in;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_load   = r_ram_load;
    assign o_word_count = r_word_count;

    // Operation sequencer: latches the request and issues one RAM write per cycle
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_base       <= '0;
            r_len        <= '0;
            r_count      <= '0;
            r_word_count <= '0;
            r_ram_in     <= '0;
            r_ram_addr   <= '0;
            r_ram_load   <= 1'b0;
        end else begin
            r_ram_load <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_base       <= i_base_addr;
                        r_len        <= w_len_clamped;
                        r_count      <= '0;
                        r_word_count <= '0;
                        if (w_len_clamped == '0) begin
                            r_state <= ST_DONE;
                        end else if (i_clear_mode) begin
                            r_state <= ST_CLEAR;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_CLEAR: begin
                    r_ram_in     <= '0;
                    r_ram_addr   <= w_addr;
                    r_ram_load   <= 1'b1;
                    r_count      <= CNT_W'(r_count + CNT_W'(1));
                    r_word_count <= CNT_W'(r_word_count + CNT_W'(1));
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_LOAD: begin
                    if (i_s_valid) begin
                        r_ram_in     <= i_s_data;
                        r_ram_addr   <= w_addr;
                        r_ram_load   <= 1'b1;
                        r_count      <= CNT_W'(r_count + CNT_W'(1));
                        r_word_count <= CNT_W'(r_word_count + CNT_W'(1));
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef RAM64_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    assign o_checksum = r_checksum;

    // Running sum of streamed words; cleared by each accepted start
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_checksum <= '0;
        end else if (r_state == ST_IDLE && i_start) begin
            r_checksum <= '0;
        end else if (r_state == ST_LOAD && i_s_valid) begin
            r_checksum <= DATA_W'(r_checksum + i_s_data);
        end
    end
`endif

endmodule

// File: doc/ram64_loader.md
Name: ram64_loader

Overview:
- Sequential write-stream front end that sits directly upstream of the 64-word, 16-bit RAM64 block.
- Accepts a burst of 16-bit words over a valid/ready stream and writes them to consecutive RAM64 addresses from a programmable base address.
- Also provides a clear mode that zero-fills a region with no stream input.
- Drives the RAM64 in/addr/load inputs from registered outputs; never reads RAM64.

Parameters:
- none (data width fixed at 16, address width fixed at 6 to match RAM64)

Ports:
- clk  input  1  rising-edge clock, shared with RAM64
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin an operation; sampled only in IDLE
- clear_mode  input  1  sampled with start; 1 = zero-fill, 0 = stream load
- base_addr  input  6  first RAM64 address; sampled with start
- length  input  7  word count, 0..64; sampled with start
- s_data  input  16  stream data word
- s_valid  input  1  stream word present
- s_ready  output  1  loader accepts a word this cycle
- ram_in  output  16  to RAM64 in (registered)
- ram_addr  output  6  to RAM64 addr (registered)
- ram_load  output  1  to RAM64 load (registered)
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle completion pulse
- word_count  output  7  words written by the current or most recent operation

Behaviour:
- States: IDLE, CLEAR, LOAD, DONE; state register resets to IDLE.
- Reset values (asynchronous, take effect immediately): ram_load=0, ram_in=0, ram_addr=0, s_ready=0, done=0, busy=0, word_count=0, internal length/base/count=0.
- Reset mid-operation forces ram_load low at once, so no write is issued at the next edge; the operation is abandoned and not resumed.
- IDLE, start=1 at an edge:
  - latch base_addr and length; clear word_count.
  - length=0 -> DONE (no writes).
  - else clear_mode=1 -> CLEAR.
  - else -> LOAD.
- start is ignored in every state except IDLE.
- CLEAR: one write per cycle with no stream involvement.
  - At each edge, register ram_in=0, ram_addr=(base+count) mod 64, ram_load=1; then count++ and word_count++.
  - After the edge that registers write number length, go to DONE.
- LOAD:
  - s_ready=1, combinational from state only; it does not depend on s_valid.
  - Accept at edge when s_valid && s_ready: register ram_in=s_data, ram_addr=(base+count) mod 64, ram_load=1; then count++ and word_count++.
  - No accept at edge: ram_load registered 0.
  - The accept of word number length moves the FSM to DONE, so s_ready is 0 in the following cycle.
  - s_data is ignored when there is no accept.
- Latency: one cycle from accept to ram_load high; RAM64 captures the word at the next rising edge.
- Throughput: one word per cycle.
- DONE:
  - Lasts exactly one cycle; done=1 and busy=1.
  - ram_load in this cycle reflects the final write, if one was registered.
  - Next edge: -> IDLE, ram_load=0.
  - All writes are committed in RAM64 by the edge that ends the done pulse.
- Address arithmetic:
  - 6-bit wrap-around (base=62, length=4 writes 62, 63, 0, 1).
  - length=64 covers every address exactly once.
  - length>64 is not possible (7-bit input is clamped: values 65..127 are treated as 64).
- word_count holds its final value until the next accepted start.
- ram_in/ram_addr hold their last values while ram_load=0.

Optional Feature:
- Macro: RAM64_LOADER_CHECKSUM_EN.
- When defined:
  - adds output port checksum (16 bits) = modulo-2^16 sum of every word registered to ram_in during LOAD.
  - CLEAR contributes 0.
  - Resets to 0 and clears on accepted start.
  - Final value is valid in the DONE cycle and holds until the next start.
- When undefined: the port and adder are absent; all other behaviour is identical.

Test Plan:
- Reset then start, clear_mode=0, base=5, length=3; stream 0x1111, 0x2222, 0x3333 with s_valid held high -> ram_load high for 3 consecutive cycles with addr 5, 6, 7; done pulses once with the 3rd ram_load; word_count=3; RAM64 reads back those values.
- Same load with s_valid toggled 1,0,1,0,1 -> exactly 3 writes; no ram_load in the gap cycles; s_ready drops the cycle after the 3rd accept.
- clear_mode=1, base=62, length=4 after RAM pre-filled with 0xFFFF -> writes 0 to 62, 63, 0, 1; address 2 still reads 0xFFFF.
- start with length=0 -> busy one cycle, done pulse, no ram_load, word_count=0; start asserted while busy during a 64-word load -> ignored, word_count ends at 64.
- reset asserted asynchronously mid-way through a length=8 load after 4 accepts -> ram_load low before the next edge, state IDLE, word_count=0, only 4 addresses modified.
- With RAM64_LOADER_CHECKSUM_EN: load 0x8000, 0x8001, 0x0003 -> checksum=0x0004 in the DONE cycle; a subsequent CLEAR run -> checksum=0x0000.
